// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared types and sizing helpers for the vector store path
package vlsu_pkg;
  localparam int unsigned DefaultAxiDataWidth = 128;
  localparam int unsigned DefaultMaxTxnBytes = 4096;
  function automatic int unsigned bus_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction
  function automatic int unsigned bus_bsize(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction
  localparam int unsigned StoreOffW = bus_bsize(DefaultAxiDataWidth);
  localparam int unsigned StoreNbW = $clog2(DefaultMaxTxnBytes) + 1;
  typedef struct packed {
    logic [StoreOffW-1:0] addr_off;
    logic [StoreNbW-1:0] nbytes;
  } store_txn_t;
  typedef enum logic {IDLE, ACTIVE} store_state_e;
endpackage

// File: rtl/store_align_buf.sv
// store_align_buf: 2*BusBytes byte FIFO-like buffer with append-N at the tail and pop-N from the head
module store_align_buf #(
  parameter int unsigned BusBytes = 16,
  localparam int unsigned NW = $clog2(BusBytes) + 1,
  localparam int unsigned CntW = $clog2(2 * BusBytes) + 1,
  localparam int unsigned BufW = 16 * BusBytes
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [8*BusBytes-1:0] push_data_i,
  input  logic [NW-1:0]         push_n_i,
  input  logic                  pop_i,
  input  logic [NW-1:0]         pop_n_i,
  output logic [8*BusBytes-1:0] head_o,
  output logic [CntW-1:0]       cnt_o
);
  logic [BufW-1:0] buf_q, kept, incoming;
  logic [CntW-1:0] base;
  // bytes at or above cnt are kept zero, so the appended bytes can simply be OR-ed in
  always_comb begin
    base = cnt_o - (pop_i ? CntW'(pop_n_i) : '0);
    kept = buf_q >> (pop_i ? {pop_n_i, 3'b000} : '0);
    incoming = (BufW'(push_data_i) & ~({BufW{1'b1}} << {push_n_i, 3'b000})) << {base, 3'b000};
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_o <= '0;
    end else begin
      buf_q <= kept | (push_i ? incoming : '0);
      cnt_o <= base + (push_i ? CntW'(push_n_i) : '0);
    end
  assign head_o = buf_q[8*BusBytes-1:0];
endmodule

// File: rtl/sequential_store.sv
// sequential_store: packs the deshuffled store byte stream into offset-aligned AXI W beats with strobe and last
module sequential_store
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth = DefaultAxiDataWidth,
  parameter int unsigned MaxTxnBytes = DefaultMaxTxnBytes,
  localparam int unsigned BusBytes = bus_bytes(AxiDataWidth),
  localparam int unsigned busBSize = bus_bsize(AxiDataWidth),
  localparam int unsigned NbW = $clog2(MaxTxnBytes) + 1,
  localparam int unsigned CntW = $clog2(2 * BusBytes) + 1,
  localparam int unsigned NW = busBSize + 1
)(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    txn_valid_i,
  output logic                    txn_ready_o,
  input  logic [busBSize-1:0]     txn_addr_off_i,
  input  logic [NbW-1:0]          txn_nbytes_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [AxiDataWidth-1:0] rx_data_i,
  input  logic [busBSize:0]       rx_nbytes_i,
  output logic                    axi_w_valid_o,
  input  logic                    axi_w_ready_i,
  output logic [AxiDataWidth-1:0] axi_w_data_o,
  output logic [BusBytes-1:0]     axi_w_strb_o,
  output logic                    axi_w_last_o,
  output logic                    txn_done_o
);
  store_state_e state_q;
  store_txn_t txn_q;
  logic zero_done_q, w_hs, rx_hs;
  logic [busBSize-1:0] off;
  logic [NbW-1:0] rem;
  logic [NW-1:0] room, need;
  logic [CntW-1:0] cnt;
  logic [AxiDataWidth-1:0] head;
  always_comb begin
    off = busBSize'(txn_q.addr_off);
    rem = NbW'(txn_q.nbytes);
    room = NW'(BusBytes) - NW'(off);
    need = (NbW'(room) < rem) ? room : NW'(rem);
    axi_w_valid_o = (state_q == ACTIVE) && (CntW'(need) <= cnt);
    axi_w_data_o = axi_w_valid_o ? (head & ~({AxiDataWidth{1'b1}} << {need, 3'b000})) << {off, 3'b000} : '0;
    axi_w_strb_o = axi_w_valid_o ? (~({BusBytes{1'b1}} << need)) << off : '0;
    axi_w_last_o = axi_w_valid_o && (NbW'(need) == rem);
    txn_ready_o = (state_q == IDLE);
    rx_ready_o = (cnt <= CntW'(BusBytes));
    w_hs = axi_w_valid_o && axi_w_ready_i;
    rx_hs = rx_valid_i && rx_ready_o;
    txn_done_o = zero_done_q || (w_hs && axi_w_last_o);
  end
  store_align_buf #(.BusBytes(BusBytes)) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (rx_hs),
    .push_data_i (rx_data_i),
    .push_n_i    (rx_nbytes_i),
    .pop_i       (w_hs),
    .pop_n_i     (need),
    .head_o      (head),
    .cnt_o       (cnt)
  );
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state_q <= IDLE;
      txn_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (txn_valid_i) begin
          txn_q <= '{addr_off: StoreOffW'(txn_addr_off_i), nbytes: StoreNbW'(txn_nbytes_i)};
          zero_done_q <= (txn_nbytes_i == '0);
          state_q <= (txn_nbytes_i == '0) ? IDLE : ACTIVE;
        end
      end else if (w_hs) begin
        txn_q.addr_off <= '0;
        txn_q.nbytes <= StoreNbW'(rem - NbW'(need));
        if (axi_w_last_o) state_q <= IDLE;
      end
    end
  // a transaction must not run past the 4 KiB page it starts in
  always_ff @(posedge clk_i)
    if (rst_ni && txn_valid_i && txn_ready_o)
      assert (int'(txn_addr_off_i) + int'(txn_nbytes_i) <= int'(MaxTxnBytes));
endmodule

// File: tb/tb_sequential_store.sv
// tb_sequential_store: random and directed stimulus checked against a byte-queue model of the store packer
module tb_sequential_store;
  localparam int BB = 16;
  logic clk_i = 0, rst_ni = 0;
  logic txn_valid_i = 0, txn_ready_o;
  logic [3:0] txn_addr_off_i = 0;
  logic [12:0] txn_nbytes_i = 0;
  logic rx_valid_i = 0, rx_ready_o;
  logic [127:0] rx_data_i = 0;
  logic [4:0] rx_nbytes_i = 0;
  logic axi_w_valid_o, axi_w_ready_i = 0, axi_w_last_o, txn_done_o;
  logic [127:0] axi_w_data_o;
  logic [15:0] axi_w_strb_o;
  always #5 clk_i = ~clk_i;
  sequential_store #(.AxiDataWidth(128), .MaxTxnBytes(4096)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .txn_valid_i(txn_valid_i), .txn_ready_o(txn_ready_o),
    .txn_addr_off_i(txn_addr_off_i), .txn_nbytes_i(txn_nbytes_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rx_data_i(rx_data_i), .rx_nbytes_i(rx_nbytes_i),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
    .axi_w_last_o(axi_w_last_o), .txn_done_o(txn_done_o)
  );
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  byte unsigned src_q[$], str_q[$];
  int t_off[$], t_rem[$];
  logic [15:0] strb_log[$];
  logic [127:0] data_log[$];
  int done_cnt = 0;
  bit zero_pend = 0, rx_fire = 0, hold_v = 0, rx_full = 0, ready_low = 0, saw_block = 0;
  logic [127:0] hold_d;
  logic [15:0] hold_s;
  logic hold_l;
  // model: accepted bytes form one stream; each beat takes min(BB-off, rem) of them into lanes off..
  always @(negedge clk_i) begin
    bit exp_done;
    int need;
    logic [127:0] ed;
    logic [15:0] es;
    if (!rst_ni) begin
      str_q.delete(); t_off.delete(); t_rem.delete();
      zero_pend = 0; hold_v = 0; rx_fire = 0;
    end else begin
      exp_done = zero_pend;
      zero_pend = 0;
      if (hold_v) begin
        check("hold_valid", 128'(axi_w_valid_o), 1);
        check("hold_data", axi_w_data_o, hold_d);
        check("hold_strb", 128'(axi_w_strb_o), 128'(hold_s));
        check("hold_last", 128'(axi_w_last_o), 128'(hold_l));
      end
      hold_v = axi_w_valid_o && !axi_w_ready_i;
      hold_d = axi_w_data_o; hold_s = axi_w_strb_o; hold_l = axi_w_last_o;
      if (axi_w_valid_o && axi_w_ready_i) begin
        strb_log.push_back(axi_w_strb_o);
        data_log.push_back(axi_w_data_o);
        check("w_txn_open", 128'(t_off.size() > 0), 1);
        if (t_off.size() > 0) begin
          need = (BB - t_off[0] < t_rem[0]) ? BB - t_off[0] : t_rem[0];
          check("w_bytes_avail", 128'(str_q.size() >= need), 1);
          ed = '0; es = '0;
          for (int i = 0; i < need && str_q.size() > 0; i++) begin
            ed[(t_off[0] + i) * 8 +: 8] = str_q.pop_front();
            es[t_off[0] + i] = 1'b1;
          end
          t_rem[0] -= need;
          t_off[0] = 0;
          check("w_data", axi_w_data_o, ed);
          check("w_strb", 128'(axi_w_strb_o), 128'(es));
          check("w_last", 128'(axi_w_last_o), 128'(t_rem[0] == 0));
          if (t_rem[0] == 0) begin
            exp_done = 1;
            void'(t_off.pop_front());
            void'(t_rem.pop_front());
          end
        end
      end
      check("done", 128'(txn_done_o), 128'(exp_done));
      if (txn_done_o) done_cnt++;
      if (txn_valid_i && txn_ready_o) begin
        if (txn_nbytes_i == 0) zero_pend = 1;
        else begin
          t_off.push_back(int'(txn_addr_off_i));
          t_rem.push_back(int'(txn_nbytes_i));
        end
      end
      rx_fire = rx_valid_i && rx_ready_o;
      if (rx_fire) for (int i = 0; i < int'(rx_nbytes_i); i++) str_q.push_back(rx_data_i[i*8 +: 8]);
      if (!rx_ready_o) saw_block = 1;
    end
  end
  initial forever begin
    @(posedge clk_i); #1;
    if (!(rx_valid_i && !rx_fire)) begin
      rx_valid_i = 0;
      if (src_q.size() > 0 && (rx_full || $urandom_range(0, 3) != 0)) begin
        automatic int mx = src_q.size() < BB ? src_q.size() : BB;
        automatic int n = rx_full ? mx : int'($urandom_range(0, mx));
        rx_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < n; i++) rx_data_i[i*8 +: 8] = src_q.pop_front();
        rx_nbytes_i = 5'(n);
        rx_valid_i = 1;
      end
    end
  end
  initial forever begin
    @(posedge clk_i); #1;
    axi_w_ready_i = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  task automatic feed(input int n, input bit seq);
    for (int i = 0; i < n; i++) src_q.push_back(seq ? 8'(i) : 8'($urandom()));
  endtask
  task automatic send_txn(input int off, input int n);
    bit ok = 0;
    @(posedge clk_i); #1;
    txn_addr_off_i = 4'(off); txn_nbytes_i = 13'(n); txn_valid_i = 1;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk_i);
      ok = txn_ready_o;
    end
    check("txn_accept", 128'(ok), 1);
    @(posedge clk_i); #1;
    txn_valid_i = 0;
  endtask
  task automatic wait_drain();
    int c = 0;
    while ((t_off.size() != 0 || zero_pend) && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    check("drain", 128'(t_off.size()), 0);
    repeat (2) @(negedge clk_i);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_txn_ready"}, 128'(txn_ready_o), 1);
    check({tag, "_rx_ready"}, 128'(rx_ready_o), 1);
    check({tag, "_w_valid"}, 128'(axi_w_valid_o), 0);
    check({tag, "_w_last"}, 128'(axi_w_last_o), 0);
    check({tag, "_done"}, 128'(txn_done_o), 0);
    check({tag, "_data"}, axi_w_data_o, 0);
    check({tag, "_strb"}, 128'(axi_w_strb_o), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("rst");
    @(posedge clk_i); #1;
    rst_ni = 1;
    strb_log.delete(); data_log.delete(); d0 = done_cnt;
    feed(32, 1); send_txn(0, 32); wait_drain();
    check("al_beats", 128'(strb_log.size()), 2);
    check("al_strb0", 128'(strb_log[0]), 'hFFFF);
    check("al_strb1", 128'(strb_log[1]), 'hFFFF);
    check("al_done", 128'(done_cnt - d0), 1);
    strb_log.delete(); data_log.delete();
    feed(16, 1); send_txn(5, 16); wait_drain();
    check("mis_beats", 128'(strb_log.size()), 2);
    check("mis_strb0", 128'(strb_log[0]), 'hFFE0);
    check("mis_strb1", 128'(strb_log[1]), 'h001F);
    check("mis_data0", data_log[0], 128'h0A090807060504030201000000000000);
    check("mis_data1", data_log[1], 128'h0000000000000000000000_0F0E0D0C0B);
    strb_log.delete();
    feed(3, 1); send_txn(0, 3); wait_drain();
    check("short_beats", 128'(strb_log.size()), 1);
    check("short_strb", 128'(strb_log[0]), 'h0007);
    strb_log.delete(); data_log.delete();
    rx_full = 1;
    feed(16, 1); send_txn(0, 10); send_txn(10, 6); wait_drain();
    rx_full = 0;
    check("res_beats", 128'(strb_log.size()), 2);
    check("res_strbA", 128'(strb_log[0]), 'h03FF);
    check("res_strbB", 128'(strb_log[1]), 'hFC00);
    check("res_dataB", data_log[1], 128'h0F0E0D0C0B0A_00000000000000000000);
    strb_log.delete(); d0 = done_cnt;
    send_txn(0, 0); wait_drain();
    check("zero_beats", 128'(strb_log.size()), 0);
    check("zero_done", 128'(done_cnt - d0), 1);
    strb_log.delete();
    ready_low = 1; rx_full = 1;
    feed(64, 1); send_txn(0, 64);
    saw_block = 0;
    repeat (10) @(posedge clk_i);
    check("bp_rx_block", 128'(saw_block), 1);
    ready_low = 0;
    wait_drain();
    rx_full = 0;
    check("bp_beats", 128'(strb_log.size()), 4);
    foreach (strb_log[i]) check("bp_strb", 128'(strb_log[i]), 'hFFFF);
    for (int k = 0; k < 40; k++) begin
      automatic int n = $urandom_range(0, 70);
      feed(n, 0);
      send_txn($urandom_range(0, 15), n);
    end
    wait_drain();
    check("rand_stream_empty", 128'(str_q.size()), 0);
    feed(40, 0); send_txn(3, 40);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 0;
    src_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("mid_rst");
    @(posedge clk_i); #1;
    rst_ni = 1;
    strb_log.delete();
    feed(16, 1); send_txn(0, 16); wait_drain();
    check("post_rst_beats", 128'(strb_log.size()), 1);
    check("post_rst_strb", 128'(strb_log[0]), 'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sequential_store.md
Name: sequential_store

Overview:
- Store-direction counterpart of the load path. Takes a contiguous byte stream of deshuffled vector store data and packs it into AXI W beats.
- Realigns each beat to the transaction's start-address offset, and generates wstrb and wlast.
- Sits between the store deshuffle stage (upstream) and the AXI W channel (downstream). A per-transaction control interface from the address generator tells it the offset and byte count.

Parameters:
- AxiDataWidth, 128, W data width in bits. Must be a power of two and at least 32.
- MaxTxnBytes, 4096, maximum bytes in one AXI transaction (the 4 KiB boundary).
- localparam BusBytes = AxiDataWidth/8.
- localparam busBSize = $clog2(BusBytes).
- localparam NbW = $clog2(MaxTxnBytes)+1.
- localparam CntW = $clog2(2*BusBytes)+1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- txn_valid_i  in  1  transaction control valid.
- txn_ready_o  out  1  transaction control ready.
- txn_addr_off_i  in  busBSize  start address modulo BusBytes.
- txn_nbytes_i  in  NbW  total bytes in the transaction, 0..MaxTxnBytes.
- rx_valid_i  in  1  store byte-stream valid.
- rx_ready_o  out  1  store byte-stream ready.
- rx_data_i  in  AxiDataWidth  stream bytes, packed from byte 0.
- rx_nbytes_i  in  busBSize+1  count of valid bytes in rx_data_i, 0..BusBytes.
- axi_w_valid_o  out  1  W valid.
- axi_w_ready_i  in  1  W ready.
- axi_w_data_o  out  AxiDataWidth  W data.
- axi_w_strb_o  out  BusBytes  W strobe.
- axi_w_last_o  out  1  W last.
- txn_done_o  out  1  one-cycle pulse on the last-beat handshake, for B-response tracking.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - state=IDLE; buffer count cnt=0; rem=0; off=0.
  - Buffer contents are don't-care.
  - Outputs: txn_ready_o=1; rx_ready_o=1; axi_w_valid_o=0; axi_w_last_o=0; txn_done_o=0; data and strb are 0.
  - A reset mid-transaction discards buffered bytes and the transaction with no further W beats.
- Byte buffer:
  - Register of 2*BusBytes bytes with occupancy cnt (0..2*BusBytes).
  - rx_ready_o = (cnt <= BusBytes). This depends only on registered state.
  - An rx handshake appends rx_nbytes_i bytes at position cnt. rx_nbytes_i=0 is accepted and discarded.
  - The buffer is a continuous stream. Bytes beyond the current transaction stay buffered for the next one.
- FSM IDLE:
  - txn_ready_o=1. On the txn handshake, latch off=txn_addr_off_i and rem=txn_nbytes_i.
  - If txn_nbytes_i=0: stay in IDLE, no beats, pulse txn_done_o next cycle.
  - Otherwise go to ACTIVE.
- FSM ACTIVE:
  - txn_ready_o=0.
  - need = min(BusBytes-off, rem).
  - axi_w_valid_o = (cnt >= need). Registered-state only; there is no combinational rx->W path.
  - axi_w_data_o: buffer bytes [0, need) placed at byte lanes [off, off+need). Other lanes are 0.
  - axi_w_strb_o: bits [off, off+need) set.
  - axi_w_last_o = (rem == need).
  - W handshake: pop need bytes (shift the buffer down), rem -= need, off = 0.
  - If last: pulse txn_done_o the same cycle, go to IDLE.
  - Beat count = ceil((off+nbytes)/BusBytes).
- Simultaneous rx append and W pop in one cycle:
  - cnt' = cnt - need + rx_nbytes.
  - Append position is cnt - need.
  - No byte lost or duplicated.
- While axi_w_valid_o=1 and ready=0, data, strb and last are held stable (AXI rule).
- Turnaround: new txn is accepted one cycle after the last beat (one bubble on txn_ready_o).
- Latency: first W beat is valid the cycle after the buffer holds need bytes and state=ACTIVE.
- Illegal input: off+nbytes crossing 4 KiB. Flagged by assertion only.

Decomposition:
- vlsu_pkg holds:
  - the store txn control struct (addr_off, nbytes);
  - the BusBytes / busBSize helper functions.
- Sub-module store_align_buf: 2*BusBytes byte buffer with append-N/pop-N and a count output. It is natural to split out and is unit-testable alone.
- FSM, strobe and shift logic stay in sequential_store.

Test Plan (AxiDataWidth=128, so BusBytes=16):
- Aligned transfer: off=0, nbytes=32; two rx beats of 16 bytes (bytes 0x00..0x1F) -> 2 W beats, strb 0xFFFF both; last and txn_done_o on beat 2 only.
- Misaligned transfer: off=5, nbytes=16; rx 16 bytes 0x00..0x0F.
  - Beat 0: strb 0xFFE0, lanes 5..15 = 0x00..0x0A.
  - Beat 1: strb 0x001F, lanes 0..4 = 0x0B..0x0F, last=1.
- Short transfer: off=0, nbytes=3 -> single beat, strb 0x0007, last=1.
- Residual across transactions: one rx of 16 bytes; txn A (off=0, nbytes=10) then txn B (off=10, nbytes=6).
  - A: strb 0x03FF, last.
  - B: strb 0xFC00, lanes 10..15 = bytes 10..15, last.
  - No extra rx needed for B.
- Backpressure: off=0, nbytes=64; axi_w_ready_i=0 for 10 cycles while rx is streaming -> rx_ready_o drops once cnt > 16, W outputs stay stable, all 64 bytes delivered in order.
- Zero-length and reset:
  - nbytes=0 -> no W beat, txn_done_o pulse.
  - rst_ni low mid-transaction -> all outputs at reset values next cycle; a subsequent aligned 16-byte transaction completes correctly.
